serial_sub8: RTL and testbench

//  Bit-serial multi-cycle subtractor: d = a - b - bin, LSB first, one full-subtractor

---
 rtl/serial_sub8.sv | 135 +++++++++++++
 tb/tb_serial_sub8.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_sub8.sv
// Bit-serial subtractor: d = a - b - bin, one full-subtractor stage per clock, LSB first.
// Operands are captured on an accepted start; results update only when the last bit retires.
module serial_sub8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             v
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // One full-subtractor stage: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] fsub(input logic ai, input logic bi, input logic br);
        logic diff_s;
        logic brw_s;
        diff_s = ai ^ bi ^ br;
        brw_s  = (~ai & bi) | (~(ai ^ bi) & br);
        return {brw_s, diff_s};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic [1:0]       step_s;
    logic             accept_s;

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        res_d    = res_q;
        d_d      = d_q;
        bout_d   = bout_q;
        v_d      = v_q;
        step_s   = fsub(a_q[cnt_q], b_q[cnt_q], br_q);
        accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    state_d = S_SHIFT;
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = {CW{1'b0}};
                    res_d   = {WIDTH{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                res_d = {step_s[0], res_q[WIDTH-1:1]};
                br_d  = step_s[1];
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    d_d     = {step_s[0], res_q[WIDTH-1:1]};
                    bout_d  = step_s[1];
                    // Overflow when operand signs differ and the result sign differs from a.
                    v_d     = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ step_s[0]);
                end else begin
                    state_d = S_SHIFT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            br_q    <= 1'b0;
            res_q   <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
    assign v    = v_q;

endmodule

// File: tb/tb_serial_sub8.sv
// Directed and random self-checking bench for serial_sub8 (WIDTH=8).
module tb_serial_sub8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       bout;
    logic       v;

    int vectors;
    int miscompares;

    serial_sub8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .v     (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {bout,d} = {0,a} - {0,b} - bin; v from operand and result signs.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin,
                         output logic [7:0] ed, output logic eb, output logic ev);
        logic [8:0] diff;
        diff = {1'b0, ma} - {1'b0, mb} - {8'd0, mbin};
        ed   = diff[7:0];
        eb   = diff[8];
        ev   = (ma[7] ^ mb[7]) & (ma[7] ^ diff[7]);
    endtask

    // Launch one operation, check latency and result, return at the done cycle.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input string tag);
        logic [7:0] ed;
        logic       eb;
        logic       ev;
        int         cyc;
        model(ta, tb, tbin, ed, eb, ev);
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb; bin = ~tbin;
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 9);
        chk({tag, "_d"}, {24'd0, d}, {24'd0, ed});
        chk({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
        chk({tag, "_v"}, {31'd0, v}, {31'd0, ev});
    endtask

    initial begin
        int         cyc;
        int         ndone;
        int         last_done;
        logic [7:0] ed;
        logic       eb;
        logic       ev;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        logic [7:0] held_d;

        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {20'd0, busy, done, bout, v, d}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {20'd0, busy, done, bout, v, d}, 32'd0);

        do_op(8'hFF, 8'h01, 1'b0, "t1_ff_01");
        @(negedge clk);
        chk("t1_done_one_cycle", {31'd0, done}, 32'd0);
        chk("t1_d_held", {24'd0, d}, 32'h0000_00FE);
        do_op(8'h01, 8'h02, 1'b0, "t2_01_02");
        do_op(8'hFF, 8'hFD, 1'b1, "t2_ff_fd");
        do_op(8'h80, 8'h01, 1'b0, "t3_80_01");
        do_op(8'h7F, 8'hFF, 1'b0, "t3_7f_ff");
        do_op(8'h00, 8'h00, 1'b1, "wrap_00_00_1");
        do_op(8'h00, 8'hFF, 1'b1, "wrap_00_ff_1");

        // Starts during busy are ignored.
        model(8'h10, 8'h03, 1'b0, ed, eb, ev);
        @(negedge clk);
        a = 8'h10; b = 8'h03; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_busy", {31'd0, busy}, 32'd1);
        ndone = 0; held_d = 8'h00;
        for (int i = 2; i < 25; i++) begin
            if (i == 3 || i == 5) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                ndone++;
                held_d = d;
            end
        end
        start = 1'b0;
        chk("t4_done_count", ndone, 1);
        chk("t4_d", {24'd0, held_d}, {24'd0, ed});
        chk("t4_bout", {31'd0, bout}, {31'd0, eb});

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a = 8'h55; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_now", {20'd0, busy, done, bout, v, d}, 32'd0);
        ndone = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("t5_no_done_after_abort", ndone, 0);
        do_op(8'h55, 8'h11, 1'b0, "t5_fresh");

        // Back-to-back with start held high.
        model(8'hC3, 8'h3C, 1'b1, ed, eb, ev);
        @(negedge clk);
        a = 8'hC3; b = 8'h3C; bin = 1'b1; start = 1'b1;
        ndone = 0; last_done = 0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone > 1) chk("t6_spacing", cyc - last_done, 9);
                chk("t6_d", {24'd0, d}, {24'd0, ed});
                last_done = cyc;
            end
        end
        start = 1'b0;
        chk("t6_done_count", ndone, 4);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            do_op(ra, rb, rbin, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
